// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - bit-serial LSB-first adder with registered carry
//
// Optional feature macro: SERIAL_ADDER_SUB_EN (adds 'sub' input for a-b).
//
// Ports:
//   clk       in   rising-edge clock
//   rst       in   synchronous active-high reset
//   start     in   begin an operation; sampled only while ready=1
//   sub       in   (SERIAL_ADDER_SUB_EN only) 1 = compute a-b, sampled with start
//   a, b      in   WIDTH-bit operands, captured on the accepted start
//   ready     out  high in IDLE
//   busy      out  high while bits are being processed
//   done      out  one-cycle pulse when sum/carry_out are fresh
//   sum       out  WIDTH-bit result, held until the next completion
//   carry_out out  final carry (for subtraction: 1 = no borrow)

module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_sr, b_sr, res_sr;
  logic             carry_reg;
  logic [CW-1:0]    count;

  logic             bit_sum, carry_nxt, last_bit, do_sub;
  logic [WIDTH-1:0] res_nxt;

  // Subtraction is a + ~b + 1: invert b on load and seed the carry with 1.
`ifdef SERIAL_ADDER_SUB_EN
  assign do_sub = sub;
`else
  assign do_sub = 1'b0;
`endif

  // One full-adder bit cell reused over WIDTH cycles.
  assign bit_sum   = a_sr[0] ^ b_sr[0] ^ carry_reg;
  assign carry_nxt = (a_sr[0] & b_sr[0]) | (carry_reg & (a_sr[0] ^ b_sr[0]));
  assign res_nxt   = {bit_sum, res_sr[WIDTH-1:1]};
  assign last_bit  = (count == LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    ready     = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      S_IDLE: begin
        ready = 1'b1;
        if (start) state_nxt = S_SHIFT;
      end
      S_SHIFT: begin
        busy = 1'b1;
        if (last_bit) state_nxt = S_DONE;
      end
      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_sr      <= '0;
      b_sr      <= '0;
      res_sr    <= '0;
      carry_reg <= 1'b0;
      count     <= '0;
      sum       <= '0;
      carry_out <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            a_sr      <= a;
            b_sr      <= do_sub ? ~b : b;
            carry_reg <= do_sub;
            count     <= '0;
          end
        end
        S_SHIFT: begin
          a_sr      <= {1'b0, a_sr[WIDTH-1:1]};
          b_sr      <= {1'b0, b_sr[WIDTH-1:1]};
          res_sr    <= res_nxt;
          carry_reg <= carry_nxt;
          count     <= count + 1'b1;
          // Outputs are published only as the final bit lands, so they stay
          // stable through DONE and IDLE until the next completion.
          if (last_bit) begin
            sum       <= res_nxt;
            carry_out <= carry_nxt;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// tb/tb_serial_adder.sv - self-checking bench for serial_adder

module tb_serial_adder;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         sub;
  logic [W-1:0] a, b;
  logic         ready, busy, done, carry_out;
  logic [W-1:0] sum;

  typedef struct packed {
    logic [W-1:0] s;
    logic         c;
  } exp_t;

  exp_t q[$];
  int   checks   = 0;
  int   failures = 0;
  int   done_cnt = 0;

  serial_adder #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
`ifdef SERIAL_ADDER_SUB_EN
    .sub       (sub),
`endif
    .a         (a),
    .b         (b),
    .ready     (ready),
    .busy      (busy),
    .done      (done),
    .sum       (sum),
    .carry_out (carry_out)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (done) done_cnt++;

  // Drive one start cycle from a negedge; optionally record the expected result.
  task automatic launch(input logic [W-1:0] av, input logic [W-1:0] bv,
                        input logic sv, input bit push);
    logic [W:0] r;
    exp_t e;
    a = av; b = bv; sub = sv; start = 1'b1;
    if (sv) r = {1'b0, av} + {1'b0, ~bv} + 9'd1;
    else    r = {1'b0, av} + {1'b0, bv};
    e.s = r[W-1:0];
    e.c = r[W];
    if (push) q.push_back(e);
    @(negedge clk);
    start = 1'b0;
    a = $urandom; b = $urandom; sub = 1'b0;
  endtask

  // Called at the first negedge after start (cycle 1); returns the cycle index
  // at which done was seen, or 0 on timeout.
  task automatic wait_done(output int n);
    n = 0;
    for (int i = 1; i <= 40; i++) begin
      if (done) begin n = i; return; end
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; sub = 1'b0; a = '0; b = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", ready); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
    checks++; if (sum !== 8'h00) begin failures++; $display("FAIL reset_sum got=%h exp=00", sum); end
    checks++; if (carry_out !== 1'b0) begin failures++; $display("FAIL reset_cout got=%b exp=0", carry_out); end
  endtask

  task automatic test_basic;
    exp_t e;
    int bad_busy = 0;
    launch(8'h0F, 8'h01, 1'b0, 1'b1);
    for (int n = 1; n <= 9; n++) begin
      if (busy !== (n <= 8) || done !== (n == 9) || ready !== 1'b0) bad_busy++;
      if (n < 9) @(negedge clk);
    end
    checks++; if (bad_busy != 0) begin failures++; $display("FAIL basic_timing got=%0d bad_cycles exp=0", bad_busy); end
    e = q.pop_front();
    checks++; if (sum !== e.s || carry_out !== e.c) begin failures++; $display("FAIL basic_result got=%h/%b exp=%h/%b", sum, carry_out, e.s, e.c); end
    repeat (3) @(negedge clk);
    checks++; if (done !== 1'b0 || ready !== 1'b1) begin failures++; $display("FAIL basic_after got=done%b ready%b exp=done0 ready1", done, ready); end
    checks++; if (sum !== 8'h10 || carry_out !== 1'b0) begin failures++; $display("FAIL basic_hold got=%h/%b exp=10/0", sum, carry_out); end
  endtask

  task automatic test_overflow;
    logic [W-1:0] av[2] = '{8'hFF, 8'hAA};
    logic [W-1:0] bv[2] = '{8'h01, 8'h55};
    exp_t e;
    int n;
    for (int k = 0; k < 2; k++) begin
      launch(av[k], bv[k], 1'b0, 1'b1);
      wait_done(n);
      checks++; if (n != 9) begin failures++; $display("FAIL ovf_latency%0d got=%0d exp=9", k, n); end
      e = q.pop_front();
      checks++; if (sum !== e.s || carry_out !== e.c) begin failures++; $display("FAIL ovf_result%0d got=%h/%b exp=%h/%b", k, sum, carry_out, e.s, e.c); end
      @(negedge clk);
    end
  endtask

  task automatic test_ignore_start;
    exp_t e;
    int n, d0;
    d0 = done_cnt;
    launch(8'h10, 8'h20, 1'b0, 1'b1);
    repeat (2) @(negedge clk);
    a = 8'hFF; b = 8'hFF; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(n);
    checks++; if (n == 0) begin failures++; $display("FAIL ignore_timeout got=no_done exp=done"); end
    e = q.pop_front();
    checks++; if (sum !== e.s || carry_out !== e.c) begin failures++; $display("FAIL ignore_result got=%h/%b exp=%h/%b", sum, carry_out, e.s, e.c); end
    repeat (15) @(negedge clk);
    checks++; if (done_cnt - d0 != 1) begin failures++; $display("FAIL ignore_pulses got=%0d exp=1", done_cnt - d0); end
  endtask

  task automatic test_reset_mid;
    exp_t e;
    int n, d0;
    d0 = done_cnt;
    launch(8'h7F, 8'h01, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b1; start = 1'b1;
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    checks++; if (ready !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL rstmid_state got=ready%b busy%b exp=ready1 busy0", ready, busy); end
    checks++; if (sum !== 8'h00 || carry_out !== 1'b0) begin failures++; $display("FAIL rstmid_sum got=%h/%b exp=00/0", sum, carry_out); end
    repeat (12) @(negedge clk);
    checks++; if (done_cnt != d0) begin failures++; $display("FAIL rstmid_nodone got=%0d exp=%0d", done_cnt, d0); end
    launch(8'h03, 8'h04, 1'b0, 1'b1);
    wait_done(n);
    e = q.pop_front();
    checks++; if (n != 9 || sum !== e.s || carry_out !== e.c) begin failures++; $display("FAIL rstmid_fresh got=%h/%b n=%0d exp=%h/%b n=9", sum, carry_out, n, e.s, e.c); end
    @(negedge clk);
  endtask

  task automatic test_back_to_back;
    exp_t e;
    int n;
    for (int k = 0; k < 6; k++) begin
      launch(W'($urandom), W'($urandom), 1'b0, 1'b1);
      wait_done(n);
      checks++; if (n != 9) begin failures++; $display("FAIL b2b_latency%0d got=%0d exp=9", k, n); end
      e = q.pop_front();
      checks++; if (sum !== e.s || carry_out !== e.c) begin failures++; $display("FAIL b2b_result%0d got=%h/%b exp=%h/%b", k, sum, carry_out, e.s, e.c); end
      @(negedge clk);
      checks++; if (ready !== 1'b1) begin failures++; $display("FAIL b2b_ready%0d got=%b exp=1", k, ready); end
    end
  endtask

`ifdef SERIAL_ADDER_SUB_EN
  task automatic test_sub;
    logic [W-1:0] av[4] = '{8'h05, 8'h07, 8'h00, 8'h80};
    logic [W-1:0] bv[4] = '{8'h07, 8'h05, 8'h00, 8'h81};
    exp_t e;
    int n;
    for (int k = 0; k < 4; k++) begin
      launch(av[k], bv[k], 1'b1, 1'b1);
      wait_done(n);
      e = q.pop_front();
      checks++; if (n != 9 || sum !== e.s || carry_out !== e.c) begin failures++; $display("FAIL sub_result%0d got=%h/%b n=%0d exp=%h/%b n=9", k, sum, carry_out, n, e.s, e.c); end
      @(negedge clk);
    end
  endtask
`endif

  initial begin
    start = 1'b0; sub = 1'b0; a = '0; b = '0; rst = 1'b1;
    @(negedge clk);
    test_reset();
    test_basic();
    test_overflow();
    test_ignore_start();
    test_reset_mid();
    test_back_to_back();
`ifdef SERIAL_ADDER_SUB_EN
    test_sub();
`endif
    checks++; if (q.size() != 0) begin failures++; $display("FAIL scoreboard_left got=%0d exp=0", q.size()); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
